// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus one memory-mapped I/O port register,
// with WAIT_STATES wait cycles between request acceptance and the access.
//   state    | meaning
//   S_IDLE   | ready, accepts iReq
//   S_WAIT   | counting wait states; access happens when the counter is zero
//   S_ACK    | one-cycle completion pulse, iReq ignored
module mem_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_ADDR     = 32'hFFFF_FFF0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oAck,
  output logic        oErr,
  output logic        oBusy,
  input  logic [31:0] iPORT,
  output logic [31:0] oPORT
);
  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_data;
  logic [31:0]       ram [DEPTH];

  logic              misaligned;
  logic              hit_io;
  logic              hit_ram;
  logic              access;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_idx;

  assign misaligned = lat_addr[1:0] != 2'b00;
  assign hit_io     = lat_addr == IO_ADDR;
  assign hit_ram    = {1'b0, lat_addr} < RAM_BYTES;
  assign ram_idx    = lat_addr[ADDR_W+1:2];
  assign access     = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign ram_we     = access && lat_write && !misaligned && !hit_io && hit_ram;
  assign oBusy      = state != S_IDLE;

  // RAM is deliberately left out of reset so its contents survive iRst.
  always_ff @(posedge iClk) begin
    if (ram_we) ram[ram_idx] <= lat_data;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
      oAck      <= 1'b0;
      oErr      <= 1'b0;
      oData     <= '0;
      oPORT     <= '0;
    end else begin
      oAck <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iReq) begin
            lat_write <= iWrite;
            lat_addr  <= iAddr;
            lat_data  <= iData;
            wait_cnt  <= WAIT_LOAD;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state <= S_ACK;
            oAck  <= 1'b1;
            oErr  <= 1'b0;
            oData <= '0;
            // Decode priority: alignment, then I/O port, then RAM window.
            if (misaligned) begin
              oErr <= 1'b1;
            end else if (hit_io) begin
              if (lat_write) oPORT <= lat_data;
              else           oData <= iPORT;
            end else if (hit_ram) begin
              if (!lat_write) oData <= ram[ram_idx];
            end else begin
              oErr <= 1'b1;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: one instance with two
// wait states, one with zero, both checked against an address-map model.
module tb_mem_responder;
  localparam logic [31:0] IO_ADDR = 32'hFFFF_FFF0;
  localparam int          WS_A    = 2;
  localparam int          WS_Z    = 0;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;

  logic        a_req = 1'b0, a_write = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, a_port_in = '0;
  logic [31:0] a_rdata, a_port_out;
  logic        a_ack, a_err, a_busy;

  logic        z_req = 1'b0, z_write = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0, z_port_in = '0;
  logic [31:0] z_rdata, z_port_out;
  logic        z_ack, z_err, z_busy;

  always #5 iClk = ~iClk;

  mem_responder #(.ADDR_W(8), .WAIT_STATES(WS_A), .IO_ADDR(IO_ADDR)) u_dut (
    .iClk(iClk), .iRst(iRst), .iReq(a_req), .iWrite(a_write), .iAddr(a_addr),
    .iData(a_wdata), .oData(a_rdata), .oAck(a_ack), .oErr(a_err), .oBusy(a_busy),
    .iPORT(a_port_in), .oPORT(a_port_out)
  );

  mem_responder #(.ADDR_W(8), .WAIT_STATES(WS_Z), .IO_ADDR(IO_ADDR)) u_dut_zw (
    .iClk(iClk), .iRst(iRst), .iReq(z_req), .iWrite(z_write), .iAddr(z_addr),
    .iData(z_wdata), .oData(z_rdata), .oAck(z_ack), .oErr(z_err), .oBusy(z_busy),
    .iPORT(z_port_in), .oPORT(z_port_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [bit [31:0]];
  logic [31:0] port_m [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mkey(input bit sel, input logic [31:0] addr);
    return {1'b0, sel, addr[31:2]};
  endfunction

  task automatic drive(input bit sel, input bit req, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] port_in);
    if (sel) begin
      z_req = req; z_write = wr; z_addr = addr; z_wdata = wdata; z_port_in = port_in;
    end else begin
      a_req = req; a_write = wr; a_addr = addr; a_wdata = wdata; a_port_in = port_in;
    end
  endtask

  task automatic run_txn(input bit sel, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] port_in);
    int          ws;
    int          n;
    bit          got;
    bit          misal, io, inram, exp_e, chk_d;
    logic [31:0] exp_d;
    ws    = sel ? WS_Z : WS_A;
    misal = addr[1:0] != 2'b00;
    io    = addr == IO_ADDR;
    inram = addr < 32'h400;
    exp_e = misal || (!io && !inram);
    chk_d = 1'b1;
    exp_d = '0;
    if (!exp_e) begin
      if (wr) begin
        if (io) port_m[sel] = wdata;
        else    mem_m[mkey(sel, addr)] = wdata;
      end else if (io) begin
        exp_d = port_in;
      end else if (mem_m.exists(mkey(sel, addr))) begin
        exp_d = mem_m[mkey(sel, addr)];
      end else begin
        chk_d = 1'b0;
      end
    end

    @(negedge iClk);
    drive(sel, 1'b1, wr, addr, wdata, port_in);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge iClk); #1;
      n++;
      if (sel ? z_ack : a_ack) got = 1'b1;
      else check_val("busy_wait", 32'(sel ? z_busy : a_busy), 32'd1);
    end
    drive(sel, 1'b0, wr, addr, wdata, port_in);
    if (!got) begin
      check_val("ack_timeout", 32'd0, 32'd1);
      return;
    end
    check_val("latency", 32'(n), 32'(ws + 2));
    check_val("err", 32'(sel ? z_err : a_err), 32'(exp_e));
    if (chk_d) check_val("rdata", sel ? z_rdata : a_rdata, exp_d);
    check_val("port_out", sel ? z_port_out : a_port_out, port_m[sel]);
    @(posedge iClk); #1;
    check_val("ack_pulse", 32'(sel ? z_ack : a_ack), 32'd0);
    check_val("idle_busy", 32'(sel ? z_busy : a_busy), 32'd0);
    if (chk_d) check_val("rdata_hold", sel ? z_rdata : a_rdata, exp_d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack"},  32'(a_ack),  32'd0);
    check_val({tag, "_err"},  32'(a_err),  32'd0);
    check_val({tag, "_busy"}, 32'(a_busy), 32'd0);
    check_val({tag, "_data"}, a_rdata,     32'd0);
    check_val({tag, "_port"}, a_port_out,  32'd0);
    check_val({tag, "_zport"}, z_port_out, 32'd0);
  endtask

  task automatic back_to_back();
    logic [31:0] exp_d;
    bit          exp_ack, exp_busy;
    int          per;
    per   = WS_A + 3;
    exp_d = mem_m[mkey(1'b0, 32'h10)];
    @(negedge iClk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, '0, '0);
    for (int i = 0; i < 6 * per; i++) begin
      @(posedge iClk); #1;
      exp_ack  = (i % per) == WS_A + 1;
      exp_busy = (i % per) != WS_A + 2;
      check_val("b2b_ack",  32'(a_ack),  32'(exp_ack));
      check_val("b2b_busy", 32'(a_busy), 32'(exp_busy));
      if (exp_ack) check_val("b2b_rdata", a_rdata, exp_d);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h10, '0, '0);
    @(posedge iClk); #1;
    check_val("b2b_stop", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          sel, wr, got;
    int          cls;
    logic [31:0] addr, wd;

    port_m[0] = '0;
    port_m[1] = '0;
    #2 iRst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge iClk) iRst = 1'b0;

    // Directed RAM, I/O and error cases
    run_txn(1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, '0);
    run_txn(1'b0, 1'b0, 32'h10,  '0, '0);
    run_txn(1'b0, 1'b1, 32'h3FC, 32'h0BAD_F00D, '0);
    run_txn(1'b0, 1'b0, 32'h3FC, '0, '0);
    run_txn(1'b0, 1'b1, IO_ADDR, 32'h0000_00A5, '0);
    run_txn(1'b0, 1'b0, IO_ADDR, '0, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 32'h0,   32'h1111_1111, '0);
    run_txn(1'b0, 1'b1, 32'h402, 32'h2222_2222, '0);
    run_txn(1'b0, 1'b0, 32'h0,   '0, '0);
    run_txn(1'b0, 1'b0, 32'h400, '0, '0);

    // Zero wait-state instance
    run_txn(1'b1, 1'b1, 32'h40, 32'h5A5A_0040, '0);
    run_txn(1'b1, 1'b0, 32'h40, '0, '0);

    // Reset during WAIT aborts the write
    run_txn(1'b0, 1'b1, 32'h20, 32'hA0A0_0020, '0);
    run_txn(1'b0, 1'b0, 32'h20, '0, '0);
    @(negedge iClk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h5555_AAAA, '0);
    @(posedge iClk);
    @(posedge iClk); #3;
    iRst = 1'b1;
    #1 check_reset_outputs("abort");
    @(negedge iClk) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge iClk) iRst = 1'b0;
    port_m[0] = '0;
    port_m[1] = '0;
    run_txn(1'b0, 1'b0, 32'h20, '0, '0);

    // Reset during ACK: write already done, outputs still cleared
    run_txn(1'b0, 1'b1, IO_ADDR, 32'hCAFE_0001, '0);
    @(negedge iClk);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h3030_3030, '0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge iClk); #1;
      if (a_ack) got = 1'b1;
    end
    check_val("ack_seen", 32'(got), 32'd1);
    #2 iRst = 1'b1;
    #1 check_reset_outputs("ack_rst");
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge iClk) iRst = 1'b0;
    mem_m[mkey(1'b0, 32'h30)] = 32'h3030_3030;
    port_m[0] = '0;
    port_m[1] = '0;
    run_txn(1'b0, 1'b0, 32'h30, '0, '0);

    back_to_back();

    // Randomized mix across the whole address map
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 3) == 0;
      wr  = 1'($urandom_range(0, 1));
      cls = $urandom_range(0, 9);
      wd  = $urandom;
      if (cls <= 5)      addr = 32'($urandom_range(0, 15)) << 2;
      else if (cls == 6) addr = 32'h3FC;
      else if (cls == 7) addr = (($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3)));
      else if (cls == 8) addr = IO_ADDR;
      else               addr = 32'h400 + (32'($urandom_range(0, 1000)) << 2);
      run_txn(sel, wr, addr, wd, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
